ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
Burst access controller that sits directly upstream of the 1 MB byte-wide synchronous RAM and drives its clk/we/addr/data_in port. It accepts one burst command at a time over a valid/ready handshake and sequences consecutive byte writes or reads. Write data arrives on a streaming input. Read data returns on a streaming output with backpressure through a 2-entry skid buffer that absorbs the RAM's 1-cycle read latency.

Parameters:
ADDR_W, 20, RAM address width (byte addresses, 2^20 bytes)
DATA_W, 8, RAM data width
LEN_W, 8, burst length field width; beats = req_len + 1 (1..256)

Ports:
clk  input  1  single clock; the RAM shares it
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when req_valid & req_ready
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDR_W  start byte address
req_len  input  LEN_W  beats minus one
wr_valid  input  1  write byte valid
wr_ready  output  1  write byte accepted
wr_data  input  DATA_W  write byte
rd_valid  output  1  read byte valid
rd_ready  input  1  consumer accepts read byte
rd_data  output  DATA_W  read byte
rd_last  output  1  marks final beat of a read burst
busy  output  1  high from command accept until burst fully complete
done  output  1  one-cycle pulse at burst completion
mem_we  output  1  to RAM we
mem_addr  output  ADDR_W  to RAM addr
mem_wdata  output  DATA_W  to RAM data_in
mem_rdata  input  DATA_W  from RAM data_out (valid 1 cycle after read address)

Behaviour:
- Reset (async, rst_n=0): state IDLE, skid buffer emptied, in-flight flag cleared. Outputs: req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-burst abandons the burst and drops all buffered read data. No partial completion or done pulse is produced.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: req_ready=1. On req_valid, latch cur_addr=req_addr and beats_left=req_len. Go to WRITE if req_write=1, else READ. busy rises the cycle after acceptance.
- WRITE:
  - wr_ready=1.
  - mem_we = wr_valid (combinational); mem_wdata = wr_data; mem_addr = cur_addr.
  - On each wr_valid, cur_addr increments and beats_left decrements.
  - On the final beat (beats_left==0 & wr_valid), go to IDLE and pulse done next cycle.
  - wr_valid low stalls with no RAM write; gaps of any length are allowed.
- READ:
  - mem_we=0 always; mem_addr = cur_addr.
  - A read is issued in a cycle only if (buffer occupancy + in-flight) < 2.
  - Each issued read sets in-flight. The next cycle, mem_rdata is pushed into the buffer tagged last if it was the final beat.
  - cur_addr and beats_left advance per issued read.
  - After issuing the final read, go to DRAIN.
- DRAIN: wait until in-flight clear and buffer empty (last beat accepted by rd_ready), then go to IDLE and pulse done.
- Read output:
  - rd_valid = buffer non-empty; rd_data/rd_last come from the head entry.
  - rd_data/rd_last hold stable while rd_valid & !rd_ready.
  - Bytes are delivered in address order, with no loss or duplication under any rd_ready pattern.
- Throughput: with rd_ready held high, one byte per cycle after 1-cycle latency. Read burst of N beats: done asserts N+2 cycles after acceptance. Write burst with wr_valid continuously high: one byte per cycle, done 1 cycle after the final write.
- Address arithmetic: cur_addr increments modulo 2^ADDR_W, so 0xFFFFF wraps to 0x00000 within a burst. beats_left never underflows.
- busy=1 in WRITE/READ/DRAIN; req_ready = !busy. A new command can be accepted in the cycle done is high.
- Read-during-write hazards are not possible: only one burst is ever active.

Test Plan:
- Write burst addr=0x00010, len=3, bytes 0xA1,0xA2,0xA3,0xA4 with wr_valid high -> mem_we high 4 consecutive cycles at 0x00010..0x00013, done 1 cycle after last. A subsequent read of the same range with rd_ready=1 returns A1..A4, rd_last only on A4.
- Wrap: write len=2 at 0xFFFFF with 0x11,0x22,0x33 -> RAM addresses 0xFFFFF, 0x00000, 0x00001. Read back at 0xFFFFF returns 0x11,0x22,0x33.
- Backpressure: 8-beat read with rd_ready toggling 1,0,0,1,... -> all 8 bytes in order, never more than 2 outstanding, rd_data stable while stalled, done only after last accepted.
- Write stalls: 4-beat write with wr_valid gaps of 0/2/1 cycles -> exactly 4 mem_we pulses, correct addresses, wr_ready high throughout WRITE.
- Back-to-back: new req_valid held during done cycle -> accepted that cycle, busy stays high continuously.
- Reset mid-read after 2 of 6 bytes delivered -> rd_valid=0 and busy=0 immediately. Next command behaves normally and no stale bytes are emitted.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a byte-wide synchronous RAM: one write or read burst
// at a time, streaming write data in and read data out through a 2-entry skid buffer.
module ram_burst_ctrl #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic              done_q, done_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;

    logic [DATA_W-1:0] buf_data_q [2];
    logic [1:0]        buf_last_q;
    logic              rptr_q, wptr_q;
    logic [1:0]        cnt_q;

    logic              push, pop, issue;
    logic [1:0]        occ;

    assign rd_valid  = (cnt_q != 2'd0);
    assign rd_data   = rd_valid ? buf_data_q[rptr_q] : '0;
    assign rd_last   = rd_valid ? buf_last_q[rptr_q] : 1'b0;
    assign pop       = rd_valid && rd_ready;
    assign push      = infl_q;

    assign busy      = (state_q != S_IDLE);
    assign req_ready = !busy;
    assign done      = done_q;

    assign wr_ready  = (state_q == S_WRITE);
    assign mem_we    = wr_ready && wr_valid;
    assign mem_wdata = wr_ready ? wr_data : '0;
    assign mem_addr  = addr_q;

    // A byte popped this cycle frees its slot in time for a read issued now,
    // which keeps back-to-back reads flowing when the consumer never stalls.
    always_comb begin
        occ   = cnt_q + {1'b0, infl_q} - {1'b0, pop};
        issue = (state_q == S_READ) && (occ < 2'd2);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        done_d      = 1'b0;
        infl_d      = issue;
        infl_last_d = issue && (left_q == '0);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    left_d  = req_len;
                    state_d = req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (left_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        left_d = left_q - LEN_W'(1);
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (left_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        left_d = left_q - LEN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!infl_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            done_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            done_q      <= done_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    // RAM data arrives the cycle after issue; it is captured with its last tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q <= '0;
            rptr_q     <= 1'b0;
            wptr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                buf_data_q[wptr_q] <= mem_rdata;
                buf_last_q[wptr_q] <= infl_last_q;
                wptr_q             <= !wptr_q;
            end
            if (pop) begin
                rptr_q <= !rptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 1 MB synchronous RAM attached.
`timescale 1ns/1ps
module tb_ram_burst_ctrl;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_pop_cyc = 0;

    logic [8:0]  rq [$];
    logic [27:0] wq [$];
    logic [7:0]  wdat [8];
    int          gaps [8];
    logic [7:0]  rexp [8];

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("rd_hold_valid", 32'(rd_valid), 32'd1);
                check("rd_hold_data", 32'(rd_data), 32'(prev_data));
                check("rd_hold_last", 32'(rd_last), 32'(prev_last));
            end
            prev_stall <= rd_valid && !rd_ready;
            prev_data  <= rd_data;
            prev_last  <= rd_last;
            if (rd_valid && rd_ready) begin
                rq.push_back({rd_last, rd_data});
                last_pop_cyc <= cyc;
            end
            if (mem_we) wq.push_back({mem_addr, mem_wdata});
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] len, input string tag);
        logic [AW-1:0] ea;
        wq.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wr_valid = 1'b0;
            for (int g = 0; g < gaps[i]; g++) begin
                check({tag, "_ready_gap"}, 32'(wr_ready), 32'd1);
                @(posedge clk); #1;
            end
            wr_valid = 1'b1;
            wr_data  = wdat[i];
            check({tag, "_ready"}, 32'(wr_ready), 32'd1);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_nwr"}, 32'(wq.size()), 32'(len) + 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            ea = a + AW'(i);
            if (i < wq.size()) begin
                check({tag, "_addr"}, 32'(wq[i][27:8]), 32'(ea));
                check({tag, "_data"}, 32'(wq[i][7:0]), 32'(wdat[i]));
            end
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len,
                           input logic [3:0] pat, input bit chk_lat, input string tag);
        int d0;
        int t0;
        rq.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len; rd_ready = pat[0];
        @(posedge clk); #1;
        req_valid = 1'b0;
        t0 = cyc;
        d0 = done_cnt;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i < 400 && done_cnt == d0; i++) begin
            rd_ready = pat[i % 4];
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        check({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_nrd"}, 32'(rq.size()), 32'(len) + 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (i < rq.size()) begin
                check({tag, "_beat"}, 32'(rq[i]), 32'({(i == int'(len)), rexp[i]}));
            end
        end
        check({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_pop_cyc + 1));
        if (chk_lat) check({tag, "_latency"}, 32'(done_cyc - t0), 32'(len) + 32'd3);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int d0;
        for (int i = 0; i < 8; i++) gaps[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;

        wdat[0] = 8'hA1; wdat[1] = 8'hA2; wdat[2] = 8'hA3; wdat[3] = 8'hA4;
        do_write(20'h00010, 8'd3, "w1");
        rexp[0] = 8'hA1; rexp[1] = 8'hA2; rexp[2] = 8'hA3; rexp[3] = 8'hA4;
        do_read(20'h00010, 8'd3, 4'hF, 1'b1, "r1");

        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
        do_write(20'hFFFFF, 8'd2, "wwrap");
        check("wwrap_addr1", 32'(wq[1][27:8]), 32'h00000);
        check("wwrap_addr2", 32'(wq[2][27:8]), 32'h00001);
        rexp[0] = 8'h11; rexp[1] = 8'h22; rexp[2] = 8'h33;
        do_read(20'hFFFFF, 8'd2, 4'hF, 1'b1, "rwrap");

        for (int i = 0; i < 8; i++) begin
            wdat[i] = 8'hD0 + 8'(i);
            rexp[i] = 8'hD0 + 8'(i);
        end
        do_write(20'h00200, 8'd7, "w8");
        do_read(20'h00200, 8'd7, 4'b1001, 1'b0, "rbp");

        wdat[0] = 8'hC1; wdat[1] = 8'hC2; wdat[2] = 8'hC3; wdat[3] = 8'hC4;
        gaps[1] = 0; gaps[2] = 2; gaps[3] = 1;
        do_write(20'h00100, 8'd3, "wstall");
        for (int i = 0; i < 8; i++) gaps[i] = 0;
        rexp[0] = 8'hC1; rexp[1] = 8'hC2; rexp[2] = 8'hC3; rexp[3] = 8'hC4;
        do_read(20'h00100, 8'd3, 4'hF, 1'b1, "rstall");

        // Read command presented in the done cycle of a one-beat write.
        rq.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00300; req_len = 8'd0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; wr_valid = 1'b1; wr_data = 8'h77;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00300; req_len = 8'd0; rd_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        for (int i = 0; i < 50 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
        end
        check("b2b_done_seen", 32'(done_cnt - d0), 32'd1);
        check("b2b_nrd", 32'(rq.size()), 32'd1);
        if (rq.size() > 0) check("b2b_beat", 32'(rq[0]), 32'h177);

        // Reset in the middle of a 6-beat read.
        rq.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00200; req_len = 8'd5; rd_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 30 && rq.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        check("rstmid_ndel", 32'(rq.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rstmid_rd_valid", 32'(rd_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rstmid_nodone", 32'(done_cnt), 32'(d0));
        for (int i = 0; i < 8; i++) rexp[i] = 8'hD0 + 8'(i);
        do_read(20'h00200, 8'd3, 4'hF, 1'b1, "rpost");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
